fme_row_loader: RTL and testbench
=================================

Name: fme_row_loader

Overview:
- Feed side of the FME interpolation datapath; the counterpart to the output clipper stage.
- Accepts unsigned reference pixels serially, one per cycle, over a valid/ready handshake.
- Assembles complete reference rows into ping-pong row buffers.
- Presents each complete row in parallel to the interpolation filter array, BLOCK_ROWS rows per block, and pulses done after the last row.

Parameters:
DATAWIDTH, 8, pixel width in bits
ROW_PIXELS, 13, pixels per row (8-pixel block + 5 filter taps)
BLOCK_ROWS, 13, rows per block
IDX_W, 4, width of row index; must satisfy 2^IDX_W >= BLOCK_ROWS

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  global advance; when 0, no transfer and no state change
start  input  1  single-cycle pulse; begins a block when IDLE
in_pixel  input  DATAWIDTH  reference pixel, unsigned
in_valid  input  1  in_pixel valid
in_ready  output  1  loader accepts in_pixel this cycle
out_row  output  ROW_PIXELS*DATAWIDTH  row; pixel 0 in bits [DATAWIDTH-1:0]
out_valid  output  1  out_row holds a complete row
out_ready  input  1  filter array consumes the row
out_row_idx  output  IDX_W  index of presented row, 0..BLOCK_ROWS-1
out_last  output  1  presented row is row BLOCK_ROWS-1
busy  output  1  block in progress
done  output  1  one-cycle pulse after the last row is consumed

Behaviour:
- Reset values:
  - State IDLE.
  - Both buffers empty; wr_sel=0, rd_sel=0.
  - Column, write-row and read-row counters = 0.
  - in_ready=0, out_valid=0, out_last=0, busy=0, done=0.
  - out_row = 0, out_row_idx = 0.
- Transfers:
  - Input transfer = enable & in_valid & in_ready.
  - Output transfer = enable & out_valid & out_ready.
- State machine:
  - IDLE: start & enable -> LOAD; clear all counters and buffer-full flags. start is ignored in any other state.
  - LOAD: write side active. After the last pixel of row BLOCK_ROWS-1 is accepted -> DRAIN.
  - DRAIN: write side closed. After the output transfer of row BLOCK_ROWS-1 -> IDLE, done=1 for exactly one cycle.
- Write side:
  - in_ready = enable & (state==LOAD) & !full[wr_sel].
  - On an input transfer: buffer[wr_sel][col] <= in_pixel, col++.
  - At col==ROW_PIXELS-1: col <= 0, full[wr_sel] <= 1, wr_sel toggles, write-row counter ++.
- Read side:
  - out_valid = enable & full[rd_sel]; out_row = buffer[rd_sel]; out_row_idx = read-row counter.
  - out_last = out_valid & (read-row counter == BLOCK_ROWS-1).
  - On an output transfer: full[rd_sel] <= 0, rd_sel toggles, read-row counter ++.
- Latency: a row is presented the cycle after its last pixel is accepted. With out_ready held high, throughput is one pixel per cycle sustained, with no bubbles at row boundaries.
- Simultaneous events:
  - Filling one buffer while draining the other in the same cycle is legal; each full flag is updated independently.
  - With both buffers full, in_ready=0 until a row is consumed.
- out_valid may drop only when enable drops. While enable=0, out_row and out_row_idx hold their values.
- busy = (state != IDLE).
- Synchronous reset asserted mid-block aborts immediately to reset values. No done pulse; partial rows are discarded.
- Pixel data is passed through unmodified; no arithmetic on pixels.

Optional Feature:
- Macro FME_ROW_SOL_CHECK_EN.
- When defined:
  - Adds input in_sol (1 bit, start-of-line, sampled with in_pixel).
  - Adds output sol_err (1 bit, sticky, cleared by reset or by an accepted start).
  - On an input transfer with in_sol != (col==0): sol_err <= 1.
  - If in_sol=1 while col!=0, col resyncs to 0, the pixel is written at column 0, and the partial row is overwritten.
- When not defined: neither port exists; column alignment is implied by pixel count alone.

Test Plan:
- Basic block: reset, start, then stream 169 pixels (value = index mod 256) with out_ready=1 -> 13 rows; row 0 = 0..12 with pixel 0 in LSBs; out_row_idx 0..12; out_last only on row 12; done pulses once after row 12; busy falls with done.
- Back-pressure: out_ready=0 from start -> in_ready drops after exactly 26 accepted pixels; raising out_ready for one cycle frees one buffer, and 13 more pixels are accepted.
- enable stall: drop enable for 5 cycles mid-row 3 -> no transfers, col and outputs held; stream resumes with no lost or duplicated pixels.
- Reset mid-block: assert reset during row 6 -> all outputs at reset values next cycle; no done; a new start loads cleanly from row 0.
- start while busy: pulse start during LOAD -> ignored; counters are unaffected.
- FME_ROW_SOL_CHECK_EN: assert in_sol at col 5 of row 2 -> sol_err=1; that pixel lands at column 0; sol_err stays set until the next accepted start.

Source files
------------

// File: rtl/fme_row_loader_if.sv
// Pixel-in / row-out handshake bundle for fme_row_loader.
// FME_ROW_SOL_CHECK_EN adds the in_sol / sol_err start-of-line pair.
interface fme_row_loader_if #(
  parameter int DATAWIDTH  = 8,
  parameter int ROW_PIXELS = 13,
  parameter int IDX_W      = 4
);
  logic [DATAWIDTH-1:0]            in_pixel;
  logic                            in_valid;
  logic                            in_ready;
  logic [ROW_PIXELS*DATAWIDTH-1:0] out_row;
  logic                            out_valid;
  logic                            out_ready;
  logic [IDX_W-1:0]                out_row_idx;
  logic                            out_last;
`ifdef FME_ROW_SOL_CHECK_EN
  logic                            in_sol;
  logic                            sol_err;

  modport master (
    output in_pixel, in_valid, in_sol, out_ready,
    input  in_ready, out_row, out_valid, out_row_idx, out_last, sol_err
  );
  modport slave (
    input  in_pixel, in_valid, in_sol, out_ready,
    output in_ready, out_row, out_valid, out_row_idx, out_last, sol_err
  );
`else
  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_row, out_valid, out_row_idx, out_last
  );
  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_row, out_valid, out_row_idx, out_last
  );
`endif
endinterface

// File: rtl/fme_row_loader.sv
// FME reference row loader: serial pixels in, ping-pong row buffers, parallel rows out.
// Optional start-of-line checking/resync is enabled with FME_ROW_SOL_CHECK_EN.
module fme_row_loader #(
  parameter int DATAWIDTH  = 8,
  parameter int ROW_PIXELS = 13,
  parameter int BLOCK_ROWS = 13,
  parameter int IDX_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  fme_row_loader_if.slave   bus,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIXELS - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(BLOCK_ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] buf_q [2][ROW_PIXELS];
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, rd_sel_q;
  logic [COL_W-1:0]     col_q, wr_col;
  logic [IDX_W-1:0]     wr_row_q, rd_row_q;
  logic                 done_q;

  logic in_xfer, out_xfer, start_acc, row_end, blk_in_end, blk_out_end;

  assign bus.in_ready  = enable & (state_q == LOAD) & ~full_q[wr_sel_q];
  assign bus.out_valid = enable & full_q[rd_sel_q];
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign start_acc     = enable & start & (state_q == IDLE);

  // A start-of-line marker forces the pixel to column 0, discarding any partial row.
`ifdef FME_ROW_SOL_CHECK_EN
  assign wr_col = bus.in_sol ? '0 : col_q;
`else
  assign wr_col = col_q;
`endif

  assign row_end     = in_xfer & (wr_col == LAST_COL);
  assign blk_in_end  = row_end & (wr_row_q == LAST_ROW);
  assign blk_out_end = out_xfer & (rd_row_q == LAST_ROW);

  assign bus.out_row_idx = rd_row_q;
  assign bus.out_last    = bus.out_valid & (rd_row_q == LAST_ROW);
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

  always_comb begin
    bus.out_row = '0;
    for (int p = 0; p < ROW_PIXELS; p++) begin
      bus.out_row[p*DATAWIDTH +: DATAWIDTH] = buf_q[rd_sel_q][p];
    end
  end

  // Fill and drain touch different buffers, so both flags may change in one cycle.
  always_comb begin
    full_d = full_q;
    if (row_end)  full_d[wr_sel_q] = 1'b1;
    if (out_xfer) full_d[rd_sel_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc)   state_d = LOAD;
      LOAD:    if (blk_in_end)  state_d = DRAIN;
      DRAIN:   if (blk_out_end) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      col_q    <= '0;
      wr_row_q <= '0;
      rd_row_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) & blk_out_end;
      if (start_acc) begin
        full_q   <= '0;
        wr_sel_q <= 1'b0;
        rd_sel_q <= 1'b0;
        col_q    <= '0;
        wr_row_q <= '0;
        rd_row_q <= '0;
      end else begin
        full_q <= full_d;
        if (in_xfer) begin
          col_q <= row_end ? '0 : wr_col + COL_W'(1);
          if (row_end) begin
            wr_sel_q <= ~wr_sel_q;
            wr_row_q <= wr_row_q + IDX_W'(1);
          end
        end
        if (out_xfer) begin
          rd_sel_q <= ~rd_sel_q;
          rd_row_q <= rd_row_q + IDX_W'(1);
        end
      end
    end
  end

  // Buffers are cleared on reset so the presented row reads as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < ROW_PIXELS; p++) begin
          buf_q[b][p] <= '0;
        end
      end
    end else if (in_xfer) begin
      buf_q[wr_sel_q][wr_col] <= bus.in_pixel;
    end
  end

`ifdef FME_ROW_SOL_CHECK_EN
  logic sol_err_q;

  always_ff @(posedge clock) begin
    if (reset || start_acc) sol_err_q <= 1'b0;
    else if (in_xfer && (bus.in_sol != (col_q == '0))) sol_err_q <= 1'b1;
  end

  assign bus.sol_err = sol_err_q;
`endif

endmodule

// File: tb/tb_fme_row_loader.sv
// Randomized scoreboard bench for fme_row_loader; expected rows come from the pixel stream.
module tb_fme_row_loader;
  localparam int DW = 8;
  localparam int RP = 13;
  localparam int BR = 13;
  localparam int IW = 4;
  localparam int NP = RP * BR;

  typedef struct {
    logic [RP*DW-1:0] row;
    logic [IW-1:0]    idx;
    logic             last;
  } exp_t;

  logic clock = 1'b0;
  logic reset, enable, start, busy, done;

  fme_row_loader_if #(.DATAWIDTH(DW), .ROW_PIXELS(RP), .IDX_W(IW)) bus ();

  fme_row_loader #(.DATAWIDTH(DW), .ROW_PIXELS(RP), .BLOCK_ROWS(BR), .IDX_W(IW)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  exp_t         exp_q[$];
  logic [DW-1:0] pix [200];
  bit           sol [200];
  int           npix = 0;
  int           pidx = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           blocks_done = 0;
  bit           pend_done = 0;
  bit           start_req = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Expected rows are chunks of ROW_PIXELS consecutive pixels; the optional
  // resync inserts a 5-pixel partial row before row 2 that must be discarded.
  task automatic build_block(input bit pattern, input bit resync);
    exp_t e;
    logic [DW-1:0] v;
    npix = 0;
    pidx = 0;
    for (int r = 0; r < BR; r++) begin
      e.row  = '0;
      e.idx  = IW'(r);
      e.last = (r == BR - 1);
      if (resync && r == 2) begin
        for (int j = 0; j < 5; j++) begin
          pix[npix] = DW'($urandom);
          sol[npix] = (j == 0);
          npix++;
        end
      end
      for (int c = 0; c < RP; c++) begin
        v = pattern ? DW'((r * RP + c) % 256) : DW'($urandom);
        pix[npix] = v;
        sol[npix] = (c == 0);
        e.row[c*DW +: DW] = v;
        npix++;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start;
    @(posedge clock); #1;
    enable = 1'b1;
    start = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int max_cyc, input int pv, input int pr, input int pe,
                       input int stop_at, output int used);
    used = 0;
    while (used < max_cyc && pidx < stop_at && pidx < npix) begin
      @(posedge clock); #1;
      start = start_req;
      start_req = 1'b0;
      enable = ($urandom_range(99) < pe);
      bus.in_valid = ($urandom_range(99) < pv);
      bus.in_pixel = pix[pidx];
`ifdef FME_ROW_SOL_CHECK_EN
      bus.in_sol = sol[pidx];
`endif
      bus.out_ready = ($urandom_range(99) < pr);
      @(negedge clock);
      if (enable && bus.in_valid && bus.in_ready) pidx++;
      used++;
    end
  endtask

  task automatic finish_block;
    int u, n, b0;
    b0 = blocks_done;
    drive(3000, 100, 100, 100, npix, u);
    n = 0;
    while (blocks_done == b0 && n < 200) begin
      @(posedge clock); #1;
      start = 1'b0;
      enable = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clock);
      n++;
    end
    chk("block_done_seen", blocks_done - b0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: pops one expected row per output transfer; done must follow the last row by one cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      pend_done = 1'b0;
    end else begin
      if (done || pend_done) begin
        chk("done_pulse", done, pend_done);
        if (pend_done) chk("busy_falls_with_done", busy, 0);
      end
      if (done) blocks_done++;
      pend_done = 1'b0;
      if (enable && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("row_with_empty_queue", bus.out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_row", bus.out_row, e.row);
          chk("out_row_idx", bus.out_row_idx, e.idx);
          chk("out_last", bus.out_last, e.last);
          pend_done = e.last;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int u;
    logic [IW-1:0] idx_hold;
    logic [RP*DW-1:0] row_hold;

    reset = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.out_ready = 1'b0;
`ifdef FME_ROW_SOL_CHECK_EN
    bus.in_sol = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_row_idx", bus.out_row_idx, 0);
`ifdef FME_ROW_SOL_CHECK_EN
    chk("rst_sol_err", bus.sol_err, 0);
`endif

    // Basic block: index pattern, full throughput, exact latency to row 12 and done.
    build_block(1'b1, 1'b0);
    pulse_start();
    drive(400, 100, 100, 100, npix, u);
    chk("fill_no_bubbles_cycles", u, NP);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("last_row_next_cycle_valid", bus.out_valid, 1);
    chk("last_row_next_cycle_last", bus.out_last, 1);
    chk("last_row_next_cycle_idx", bus.out_row_idx, BR - 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("basic_done", done, 1);
    chk("basic_busy_low", busy, 0);
    chk("basic_scoreboard_drained", exp_q.size(), 0);

    // Back-pressure: two rows fill both buffers, one consume frees exactly one row.
    build_block(1'b0, 1'b0);
    pulse_start();
    drive(40, 100, 0, 100, npix, u);
    chk("bp_accepted_two_rows", pidx, 2 * RP);
    chk("bp_in_ready_low", bus.in_ready, 0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    drive(30, 100, 0, 100, npix, u);
    chk("bp_accepted_one_more_row", pidx, 3 * RP);
    finish_block();

    // enable stall in the middle of row 3.
    build_block(1'b0, 1'b0);
    pulse_start();
    drive(400, 100, 100, 100, 3 * RP + 6, u);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      enable = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clock);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 0);
      chk("stall_busy", busy, 1);
      if (k == 0) begin
        idx_hold = bus.out_row_idx;
        row_hold = bus.out_row;
      end else begin
        chk("stall_idx_hold", bus.out_row_idx, idx_hold);
        chk("stall_row_hold", bus.out_row, row_hold);
      end
    end
    finish_block();

    // start pulsed while loading must be ignored.
    build_block(1'b0, 1'b0);
    pulse_start();
    drive(400, 80, 80, 90, 20, u);
    chk("busy_in_load", busy, 1);
    start_req = 1'b1;
    finish_block();

    // Reset during row 6: aborts without done, then a fresh block loads from row 0.
    build_block(1'b0, 1'b0);
    pulse_start();
    drive(1000, 90, 70, 100, 6 * RP + 4, u);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_last", bus.out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_row", bus.out_row, 0);
    chk("abort_out_row_idx", bus.out_row_idx, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("abort_no_done", done, 0);
    end
    build_block(1'b0, 1'b0);
    pulse_start();
    finish_block();

    // Random traffic with stalls and back-pressure.
    for (int b = 0; b < 3; b++) begin
      build_block(1'b0, 1'b0);
      pulse_start();
      drive(4000, 70, 60, 85, npix, u);
      finish_block();
    end

`ifdef FME_ROW_SOL_CHECK_EN
    chk("sol_err_clean_stream", bus.sol_err, 0);
    // start-of-line at column 5 of row 2: flagged, realigned, sticky until next start.
    build_block(1'b0, 1'b1);
    pulse_start();
    drive(400, 100, 100, 100, 2 * RP + 6, u);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("sol_err_set", bus.sol_err, 1);
    finish_block();
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("sol_err_sticky", bus.sol_err, 1);
    build_block(1'b0, 1'b0);
    pulse_start();
    @(negedge clock);
    chk("sol_err_cleared_by_start", bus.sol_err, 0);
    finish_block();
    chk("sol_err_stays_clear", bus.sol_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
